serial_addsub_engine: RTL and testbench
=======================================

SERIAL_ADDSUB_ENGINE -- requirements
Module: serial_addsub_engine

Interface
REQ-001 Parameter DW, default 4: digit width in bits processed per clock; legal range DW >= 1.
REQ-002 Parameter NDIG, default 8: digits per operand word; legal range NDIG >= 1; word width = DW*NDIG.
REQ-003 clock  input  1  single clock; all state changes on posedge clock.
REQ-004 reset  input  1  asynchronous, active-low reset (reset==0 resets immediately, independent of clock).
REQ-005 start  input  1  request a new operation; first digit is presented in the same cycle.
REQ-006 mode  input  1  0 = add (x+y), 1 = subtract (x-y); sampled only when start is accepted.
REQ-007 x  input  DW  operand-x digit, least-significant digit first.
REQ-008 y  input  DW  operand-y digit, least-significant digit first.
REQ-009 s  output  DW  result digit (Mealy, combinational from state, carry, x and y).
REQ-010 s_valid  output  1  s carries a valid result digit this cycle.
REQ-011 busy  output  1  operation in progress; start is ignored.
REQ-012 done  output  1  one-cycle pulse after the last digit completes.
REQ-013 cout  output  1  word carry-out (add) or no-borrow flag (subtract) of the last completed operation.
REQ-014 ovf  output  1  two's-complement overflow of the last completed operation.

Function
REQ-015 FSM states: IDLE and RUN; a digit counter of max(1, clog2(NDIG)) bits and a carry register.
REQ-016 Digit arithmetic: {c_next, s} = x + (y XOR {DW{m}}) + cin, where m is the effective mode.
REQ-017 In IDLE with start=1: m = mode input, cin = mode, s_valid=1, and the mode is latched.
REQ-018 In IDLE with start=0: s_valid=0 and s=0.
REQ-019 In RUN: m = latched mode, cin = carry register, and s_valid=1 every cycle.
REQ-020 Accepted start with NDIG>1: carry <= c_next, count <= 1, and the FSM goes to RUN.
REQ-021 Accepted start with NDIG==1: that digit is the last digit; the FSM stays in IDLE.
REQ-022 RUN with count < NDIG-1: carry <= c_next and count increments.
REQ-023 RUN with count == NDIG-1 (last digit): FSM returns to IDLE and count clears.
REQ-024 Last digit, in either state: done <= 1, cout <= c_next, ovf <= (carry into digit MSB) XOR c_next.
REQ-025 done SHALL be high for exactly one cycle per operation, in the cycle after the last digit.
REQ-026 cout and ovf hold their values until the next operation completes.
REQ-027 busy = (state == RUN).
REQ-028 start while busy is ignored, with no effect on carry, count or mode.
REQ-029 Back-to-back operation: start in the IDLE cycle in which done is high is accepted normally; done still pulses.
REQ-030 Latency: result digit k appears in the same cycle as input digit k; done follows after NDIG cycles.

Reset
REQ-031 On reset==0: state=IDLE, count=0, carry=0, latched mode=0, done=0, cout=0, ovf=0.
REQ-032 Reset during RUN aborts the operation: no done pulse, and partial results are discarded.
REQ-033 After reset, busy=0, s_valid=0 and s=0 until start is asserted.

Structure
REQ-034 Package serial_arith_pkg SHALL hold the FSM state encoding (IDLE, RUN) and the constants MODE_ADD=0 and MODE_SUB=1.
REQ-035 Sub-module digit_adder SHALL contain the combinational adder:
- parameter DW;
- inputs a, b, cin;
- outputs sum, cout, and c_msb (carry into the MSB).
REQ-036 serial_addsub_engine SHALL instantiate exactly one digit_adder and hold all sequential logic itself.

Verification (DW=4, NDIG=2; digit order low then high)
REQ-037 Add 0x3C+0x05 (x: C,3; y: 5,0) -> s digits 1,4 (0x41); then done=1, cout=0, ovf=0.
REQ-038 Add 0x7F+0x01 -> s 0x80; cout=0, ovf=1. Add 0xFF+0x01 -> s 0x00; cout=1, ovf=0.
REQ-039 Subtract 0x10-0x01 -> s 0x0F, cout=1. Subtract 0x00-0x01 -> s 0xFF, cout=0, ovf=0. Subtract 0x80-0x01 -> s 0x7F, ovf=1.
REQ-040 start=1 with mode=1 on the RUN cycle of an add -> that start is ignored and the add result is unchanged.
REQ-041 Reset pulsed low asynchronously mid-RUN -> immediately:
- busy=0, cout=0, ovf=0;
- no done pulse;
- the next operation is correct.
REQ-042 Two operations issued back-to-back, second start in the done cycle -> both results correct and two done pulses two cycles apart.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared encodings for the digit-serial add/subtract engine.
package serial_arith_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Digit counter width; a one-digit word still gets a one-bit counter.
   function automatic int cnt_width(input int ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DW-bit adder that also exposes the carry into its MSB,
// so the engine can derive two's-complement overflow on the last digit.
module digit_adder #(
   parameter int DW = 4
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          cin,
   output logic [DW-1:0] sum,
   output logic          cout,
   output logic          c_msb
);

   generate
      if (DW == 1) begin : g_one
         assign c_msb = cin;
         assign sum   = a ^ b ^ cin;
      end else begin : g_multi
         logic [DW-2:0] lo_s;
         assign {c_msb, lo_s} = {1'b0, a[DW-2:0]} + {1'b0, b[DW-2:0]} + {{(DW-1){1'b0}}, cin};
         assign sum           = {a[DW-1] ^ b[DW-1] ^ c_msb, lo_s};
      end
   endgenerate

   // Full carry out of the MSB position.
   assign cout = (a[DW-1] & b[DW-1]) | (a[DW-1] & c_msb) | (b[DW-1] & c_msb);

endmodule

// File: rtl/serial_addsub_engine.sv
// Digit-serial add/subtract engine: one DW-bit digit per clock, LS digit first,
// result digits produced combinationally in the same cycle as their operands.
module serial_addsub_engine
   import serial_arith_pkg::*;
#(
   parameter int DW   = 4,
   parameter int NDIG = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic          mode,
   input  logic [DW-1:0] x,
   input  logic [DW-1:0] y,
   output logic [DW-1:0] s,
   output logic          s_valid,
   output logic          busy,
   output logic          done,
   output logic          cout,
   output logic          ovf
);

   localparam int CW = cnt_width(NDIG);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          carry_q, carry_d;
   logic          mode_q, mode_d;
   logic          done_q, done_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;

   logic          m_s, cin_s, active_s, last_s;
   logic [DW-1:0] sum_s;
   logic          c_next_s, c_msb_s;

   digit_adder #(.DW(DW)) u_digit_adder (
      .a     (x),
      .b     (y ^ {DW{m_s}}),
      .cin   (cin_s),
      .sum   (sum_s),
      .cout  (c_next_s),
      .c_msb (c_msb_s)
   );

   // Operand selection, last-digit detection and next-state logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      mode_d   = mode_q;
      done_d   = 1'b0;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      m_s      = mode_q;
      cin_s    = carry_q;
      active_s = 1'b0;
      last_s   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // In IDLE the digit comes straight from the inputs; mode doubles as cin.
            m_s   = mode;
            cin_s = mode;
            if (start) begin
               active_s = 1'b1;
               mode_d   = mode;
               if (NDIG == 1) begin
                  last_s = 1'b1;
               end else begin
                  last_s  = 1'b0;
                  state_d = ST_RUN;
                  carry_d = c_next_s;
                  cnt_d   = CW'(1);
               end
            end else begin
               active_s = 1'b0;
            end
         end
         ST_RUN: begin
            active_s = 1'b1;
            if (cnt_q == CW'(NDIG - 1)) begin
               last_s  = 1'b1;
               state_d = ST_IDLE;
               cnt_d   = {CW{1'b0}};
               carry_d = 1'b0;
            end else begin
               carry_d = c_next_s;
               cnt_d   = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CW{1'b0}};
            carry_d = 1'b0;
         end
      endcase

      if (last_s) begin
         done_d = 1'b1;
         cout_d = c_next_s;
         ovf_d  = c_msb_s ^ c_next_s;
      end else begin
         done_d = 1'b0;
      end
   end

   // State, counter, carry and result-flag registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CW{1'b0}};
         carry_q <= 1'b0;
         mode_q  <= MODE_ADD;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign s       = active_s ? sum_s : {DW{1'b0}};
   assign s_valid = active_s;
   assign busy    = (state_q == ST_RUN);
   assign done    = done_q;
   assign cout    = cout_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_serial_addsub_engine.sv
// Directed bench for serial_addsub_engine at DW=4, NDIG=2 (two-digit bytes).
module tb_serial_addsub_engine;

   logic       clock;
   logic       reset;
   logic       start;
   logic       mode;
   logic [3:0] x;
   logic [3:0] y;
   logic [3:0] s;
   logic       s_valid;
   logic       busy;
   logic       done;
   logic       cout;
   logic       ovf;

   int n_assert = 0;
   int n_fail   = 0;

   serial_addsub_engine #(.DW(4), .NDIG(2)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .mode    (mode),
      .x       (x),
      .y       (y),
      .s       (s),
      .s_valid (s_valid),
      .busy    (busy),
      .done    (done),
      .cout    (cout),
      .ovf     (ovf)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present both digits of one operation; checks each result digit as it appears.
   task automatic issue(input string tag, input logic m, input logic [7:0] xw,
                        input logic [7:0] yw, input logic [7:0] es);
      @(negedge clock);
      start = 1'b1; mode = m; x = xw[3:0]; y = yw[3:0];
      #1;
      chk({tag, ".s_lo"}, {4'h0, s}, {4'h0, es[3:0]});
      chk({tag, ".sv_lo"}, {7'd0, s_valid}, 8'd1);
      @(negedge clock);
      start = 1'b0; x = xw[7:4]; y = yw[7:4];
      #1;
      chk({tag, ".s_hi"}, {4'h0, s}, {4'h0, es[7:4]});
      chk({tag, ".busy"}, {7'd0, busy}, 8'd1);
   endtask

   // Idle cycle following the last digit: done pulse and word flags.
   task automatic finish(input string tag, input logic ec, input logic ev);
      @(negedge clock);
      start = 1'b0; x = 4'h0; y = 4'h0;
      #1;
      chk({tag, ".done"}, {7'd0, done}, 8'd1);
      chk({tag, ".cout"}, {7'd0, cout}, {7'd0, ec});
      chk({tag, ".ovf"}, {7'd0, ovf}, {7'd0, ev});
      chk({tag, ".idle"}, {6'd0, busy, s_valid}, 8'd0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; mode = 1'b0; x = 4'h0; y = 4'h0;
      repeat (2) @(negedge clock);
      #1;
      chk("rst.outs", {2'd0, busy, s_valid, done, cout, ovf, 1'b0}, 8'd0);
      chk("rst.s", {4'h0, s}, 8'h00);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      #1;
      chk("idle.s", {3'd0, s, s_valid}, 8'd0);

      issue("add3c05", 1'b0, 8'h3C, 8'h05, 8'h41);
      finish("add3c05", 1'b0, 1'b0);
      @(negedge clock);
      #1;
      chk("add3c05.done_once", {7'd0, done}, 8'd0);

      issue("add7f01", 1'b0, 8'h7F, 8'h01, 8'h80);
      finish("add7f01", 1'b0, 1'b1);
      issue("addff01", 1'b0, 8'hFF, 8'h01, 8'h00);
      finish("addff01", 1'b1, 1'b0);
      issue("sub1001", 1'b1, 8'h10, 8'h01, 8'h0F);
      finish("sub1001", 1'b1, 1'b0);
      issue("sub0001", 1'b1, 8'h00, 8'h01, 8'hFF);
      finish("sub0001", 1'b0, 1'b0);

      // Start with mode=1 during RUN must be ignored: 0x12+0x34 = 0x46.
      @(negedge clock);
      start = 1'b1; mode = 1'b0; x = 4'h2; y = 4'h4;
      #1;
      chk("ign.s_lo", {4'h0, s}, 8'h06);
      @(negedge clock);
      start = 1'b1; mode = 1'b1; x = 4'h1; y = 4'h3;
      #1;
      chk("ign.s_hi", {4'h0, s}, 8'h04);
      @(negedge clock);
      start = 1'b0; x = 4'h0; y = 4'h0;
      #1;
      chk("ign.done", {6'd0, done, busy}, 8'h02);
      chk("ign.flags", {6'd0, cout, ovf}, 8'h00);

      issue("sub8001", 1'b1, 8'h80, 8'h01, 8'h7F);
      finish("sub8001", 1'b1, 1'b1);

      // Asynchronous reset in the middle of a RUN.
      @(negedge clock);
      start = 1'b1; mode = 1'b0; x = 4'hF; y = 4'h1;
      @(negedge clock);
      start = 1'b0; x = 4'hF; y = 4'h0;
      #1;
      chk("ar.busy_pre", {7'd0, busy}, 8'd1);
      reset = 1'b0;
      #1;
      chk("ar.now", {4'd0, busy, s_valid, cout, ovf}, 8'd0);
      @(negedge clock);
      reset = 1'b1; x = 4'h0; y = 4'h0;
      #1;
      chk("ar.nodone1", {6'd0, done, busy}, 8'd0);
      @(negedge clock);
      #1;
      chk("ar.nodone2", {7'd0, done}, 8'd0);
      issue("ar.next", 1'b0, 8'h3C, 8'h05, 8'h41);
      finish("ar.next", 1'b0, 1'b0);

      // Back-to-back: second start lands in the done cycle of the first.
      issue("b2b1", 1'b0, 8'h7F, 8'h01, 8'h80);
      @(negedge clock);
      start = 1'b1; mode = 1'b1; x = 4'h0; y = 4'h1;
      #1;
      chk("b2b1.done", {5'd0, done, cout, ovf}, 8'h05);
      chk("b2b2.s_lo", {4'h0, s}, 8'h0F);
      @(negedge clock);
      start = 1'b0; x = 4'h1; y = 4'h0;
      #1;
      chk("b2b2.gap", {7'd0, done}, 8'd0);
      chk("b2b2.s_hi", {4'h0, s}, 8'h00);
      finish("b2b2", 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
